sm2201_camac_cycle_controller: RTL and testbench
================================================

# sm2201_camac_cycle_controller

Sequencer between the ISA slave port and the CAMAC branch on the SM2201 interface board. Decodes an 8-byte I/O window, turns ISA reads and writes of the data port into single CAMAC bus cycles, and stretches the ISA cycle via `isa_chrdy` until the crate acknowledges on `cb_prr` or a timeout expires. It also converts the crate service request `cb_zk4` into a maskable ISA IRQ line.

## Interface
- `BASE_ADDR`, 10'h110: I/O window base; `isa_addr[9:3]` must equal `BASE_ADDR[9:3]`.
- `SETUP_CYCLES`, 1: clocks that address and data are driven before `cb_strobe` (1..15).
- `TIMEOUT_CYCLES`, 64: clocks in strobe waiting for `cb_prr` before abort (1..255).
- `IRQ_LINE`, 5: index of the `isa_irq` bit driven.

Ports:
- `isa_clk` in 1: the single clock.
- `isa_reset` in 1: synchronous, active-high reset.
- `isa_ior`, `isa_iow` in 1 each: active-low ISA strobes.
- `isa_aen` in 1: DMA cycle when 1; the block ignores the cycle.
- `isa_addr` in 10: I/O address.
- `isa_data_in` in 8; `isa_data_out` out 8; `isa_data_oe` out 1.
- `isa_chrdy` out 1: 1 = ready, 0 = wait state.
- `isa_irq` out 8.
- `cb_addr` out 12; `cb_data_out` out 16; `cb_data_oe` out 1; `cb_data_in` in 16.
- `cb_strobe` out 1 and `cb_write` out 1: CAMAC cycle request and direction.
- `cb_prr` in 1: active-low crate acknowledge, asynchronous.
- `cb_zk4` in 1: active-low service request, asynchronous.

## Operation
- Register map by `isa_addr[2:0]`:
  - 0: read = DATA[7:0] and starts a CAMAC read. Write = stage DATA[7:0].
  - 1: read = latched DATA[15:8]. Write = stage DATA[15:8] and start a CAMAC write.
  - 2: read/write = ADDR[7:0].
  - 3: read/write = ADDR[11:8] (upper nibble reads 0).
  - 4: write = CTRL: bit0 clears TIMEOUT, bit1 sets IRQ_EN, bit2 clears PENDING. Read = STATUS `{busy, timeout, pending, irq_en, 4'b0}`.
  - 5–7: reads return 0; writes are ignored.
- A cycle is selected when the window matches and `isa_aen`=0. A command edge is a strobe sampled 0 while its previous sample was 1. If `isa_ior` and `isa_iow` are both 0, the cycle is ignored.
- FSM states and transitions:
  - IDLE → SETUP on a start command.
  - SETUP lasts SETUP_CYCLES clocks, driving `cb_addr`=ADDR. For writes, `cb_data_out`=DATA and `cb_data_oe`=1.
  - SETUP → STROBE, with `cb_strobe`=1.
  - STROBE → HOLD when synced `cb_prr`=0. On that edge a read latches `cb_data_in` into DATA.
  - STROBE → HOLD after TIMEOUT_CYCLES without acknowledge. This sets TIMEOUT; a read latches 16'hFFFF.
  - HOLD: `cb_strobe`=0. Waits for synced `cb_prr`=1 (skipped after a timeout), then → RELEASE.
  - RELEASE: `isa_chrdy`=1. Waits until the strobe is released, then → IDLE, and `cb_data_oe`=0.
- `cb_prr` and `cb_zk4` pass through two-flop synchronizers.
- A falling edge of synced `cb_zk4` sets PENDING. `isa_irq[IRQ_LINE]` = PENDING & IRQ_EN; all other bits are 0.
- If a `cb_zk4` edge and a clear of PENDING occur in the same cycle, set wins.
- `isa_data_oe` = window match & `isa_ior`=0 & `isa_aen`=0. `isa_data_out` is registered from the addressed register every clock.
- Writes to offsets 2–4 while busy are ignored. `isa_chrdy` prevents them on a compliant bus.
- If the ISA strobe rises early while busy, the FSM completes the CAMAC cycle regardless.

## Timing
- Reset values: `isa_chrdy`=1; every other output, ADDR, DATA, TIMEOUT, PENDING, IRQ_EN and both synchronizers = 0; FSM = IDLE.
- A reset mid-cycle drops `cb_strobe` and raises `isa_chrdy` at the reset edge.
- Command edge sampled at edge N → `isa_chrdy`=0 and SETUP entered at edge N.
- `cb_strobe` rises at edge N+SETUP_CYCLES.
- `cb_prr` low at edge M → seen at M+2 → HOLD entered. Data is valid on `isa_data_out` before `isa_chrdy` rises, with `isa_chrdy`=1 no earlier than M+3.
- Minimum wait: SETUP_CYCLES + 3 clocks.
- Maximum wait: SETUP_CYCLES + TIMEOUT_CYCLES + 1 clocks.
- The timeout counter is 8 bits, cleared on entering STROBE, and does not wrap.

## Structure
- Package `sm2201_camac_pkg`: register offsets, CTRL/STATUS bit positions, state enum (IDLE, SETUP, STROBE, HOLD, RELEASE), timeout counter width.
- Sub-module `sm2201_sync_edge`: 2-flop synchronizer plus falling-edge pulse. Instantiated for `cb_prr` and `cb_zk4`.

## Test plan
- Read, `cb_data_in`=16'h4208, `cb_prr` acknowledges 4 clocks after strobe. ADDR=12'h013. IOR at 0x110 → `isa_chrdy` low, `cb_addr`=12'h013. Then read 0x110 = 8'h08 and read 0x111 = 8'h42, with `isa_chrdy` high within SETUP+TIMEOUT+1.
- Write: 8'h34 to 0x110, then 8'h12 to 0x111 → `cb_write`=1, `cb_data_out`=16'h1234 during strobe, `isa_chrdy` released after `cb_prr` returns high.
- No acknowledge (`cb_prr` held 1) on a read → `isa_chrdy` low for exactly SETUP_CYCLES + 65 clocks, DATA reads 16'hFFFF, STATUS = 8'h40. CTRL write 8'h01 then reads STATUS = 8'h00.
- `cb_zk4` pulse with IRQ_EN=0 → `isa_irq`=0 and STATUS bit5=1. Write CTRL 8'h02 → `isa_irq`=8'h20. Write CTRL 8'h04 in the same cycle as a new zk4 edge → PENDING stays 1.
- `isa_aen`=1 during IOR at 0x110 → no `cb_strobe`, `isa_data_oe`=0. IOR at 0x118 → ignored.
- `isa_reset` asserted during STROBE → next edge `cb_strobe`=0, `isa_chrdy`=1, all registers cleared.

Source files
------------

// File: rtl/sm2201_camac_pkg.sv
// Shared constants and types for the SM2201 ISA-to-CAMAC cycle controller:
// register offsets, CTRL/STATUS bit positions, the sequencer states and the debug view.
package sm2201_camac_pkg;

    localparam int TO_CNT_W = 8;

    localparam logic [2:0] OFF_DATA_LO = 3'd0;
    localparam logic [2:0] OFF_DATA_HI = 3'd1;
    localparam logic [2:0] OFF_ADDR_LO = 3'd2;
    localparam logic [2:0] OFF_ADDR_HI = 3'd3;
    localparam logic [2:0] OFF_CTRL    = 3'd4;

    localparam int CTRL_CLR_TIMEOUT = 0;
    localparam int CTRL_SET_IRQ_EN  = 1;
    localparam int CTRL_CLR_PENDING = 2;

    localparam int STAT_BUSY    = 7;
    localparam int STAT_TIMEOUT = 6;
    localparam int STAT_PENDING = 5;
    localparam int STAT_IRQ_EN  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RELEASE
    } state_t;

    typedef struct packed {
        state_t                state;
        logic                  prr_sync;
        logic                  prr_fall;
        logic                  zk4_sync;
        logic [TO_CNT_W-1:0]   cnt;
    } dbg_t;

    function automatic logic [7:0] pack_status(input logic busy, input logic timeout,
                                               input logic pending, input logic irq_en);
        logic [7:0] s;
        s = 8'h00;
        s[STAT_BUSY]    = busy;
        s[STAT_TIMEOUT] = timeout;
        s[STAT_PENDING] = pending;
        s[STAT_IRQ_EN]  = irq_en;
        return s;
    endfunction

endpackage

// File: rtl/sm2201_camac_cycle_controller_if.sv
// ISA slave port and CAMAC branch signals of the SM2201 board. The controller
// uses the slave view; the ISA host plus crate side uses the master view.
interface sm2201_camac_cycle_controller_if;

    logic        isa_ior;
    logic        isa_iow;
    logic        isa_aen;
    logic [9:0]  isa_addr;
    logic [7:0]  isa_data_in;
    logic [7:0]  isa_data_out;
    logic        isa_data_oe;
    logic        isa_chrdy;
    logic [7:0]  isa_irq;
    logic [11:0] cb_addr;
    logic [15:0] cb_data_out;
    logic        cb_data_oe;
    logic [15:0] cb_data_in;
    logic        cb_strobe;
    logic        cb_write;
    logic        cb_prr;
    logic        cb_zk4;

    modport slave (
        input  isa_ior, isa_iow, isa_aen, isa_addr, isa_data_in,
        input  cb_data_in, cb_prr, cb_zk4,
        output isa_data_out, isa_data_oe, isa_chrdy, isa_irq,
        output cb_addr, cb_data_out, cb_data_oe, cb_strobe, cb_write
    );

    modport master (
        output isa_ior, isa_iow, isa_aen, isa_addr, isa_data_in,
        output cb_data_in, cb_prr, cb_zk4,
        input  isa_data_out, isa_data_oe, isa_chrdy, isa_irq,
        input  cb_addr, cb_data_out, cb_data_oe, cb_strobe, cb_write
    );

endinterface

// File: rtl/sm2201_sync_edge.sv
// Two-flop synchronizer for an asynchronous active-low crate line, with a
// one-clock pulse on each falling edge of the synchronized level.
module sm2201_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Flops reset low, so a line idling high after reset never produces a false fall.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/sm2201_camac_cycle_controller.sv
// ISA I/O window decoder and CAMAC single-cycle sequencer; holds the ISA bus in
// wait states via isa_chrdy until the crate acknowledges or the timeout expires.
module sm2201_camac_cycle_controller
    import sm2201_camac_pkg::*;
#(
    parameter logic [9:0] BASE_ADDR      = 10'h110,
    parameter int          SETUP_CYCLES   = 1,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter int          IRQ_LINE       = 5
) (
    input  logic                           isa_clk,
    input  logic                           isa_reset,
    sm2201_camac_cycle_controller_if.slave bus,
    output dbg_t                           o_dbg
);

    localparam logic [TO_CNT_W-1:0] SETUP_LAST = TO_CNT_W'(SETUP_CYCLES - 1);
    localparam logic [TO_CNT_W-1:0] TO_LAST    = TO_CNT_W'(TIMEOUT_CYCLES - 1);

    state_t               r_state;
    state_t               w_next_state;
    logic [TO_CNT_W-1:0]  r_cnt;
    logic                 r_ior_q;
    logic                 r_iow_q;
    logic [15:0]          r_data;
    logic [11:0]          r_addr;
    logic                 r_timeout;
    logic                 r_pending;
    logic                 r_irq_en;
    logic                 r_is_write;
    logic                 r_cyc_to;
    logic [7:0]           r_data_out;

    logic                 w_prr_sync;
    logic                 w_prr_fall;
    logic                 w_zk4_sync;
    logic                 w_zk4_fall;
    logic [2:0]           w_off;
    logic                 w_win;
    logic                 w_sel;
    logic                 w_rd_cmd;
    logic                 w_wr_cmd;
    logic                 w_idle;
    logic                 w_start_rd;
    logic                 w_start_wr;
    logic                 w_reg_wr;
    logic                 w_clr_pend;
    logic                 w_ack;
    logic                 w_to_hit;
    logic                 w_chrdy;
    logic                 w_strobe;
    logic [11:0]          w_cb_addr;
    logic [15:0]          w_cb_dout;
    logic                 w_cb_oe;
    logic                 w_cb_write;
    logic [7:0]           w_rd_mux;
    logic [7:0]           w_irq;

    sm2201_sync_edge u_prr_sync (
        .i_clk   (isa_clk),
        .i_rst   (isa_reset),
        .i_async (bus.cb_prr),
        .o_sync  (w_prr_sync),
        .o_fall  (w_prr_fall)
    );

    sm2201_sync_edge u_zk4_sync (
        .i_clk   (isa_clk),
        .i_rst   (isa_reset),
        .i_async (bus.cb_zk4),
        .o_sync  (w_zk4_sync),
        .o_fall  (w_zk4_fall)
    );

    // A command is the first clock a strobe is seen low; both strobes low is a bus fault.
    assign w_off      = bus.isa_addr[2:0];
    assign w_win      = (bus.isa_addr[9:3] == BASE_ADDR[9:3]);
    assign w_sel      = w_win & ~bus.isa_aen;
    assign w_rd_cmd   = w_sel & r_ior_q & ~bus.isa_ior & bus.isa_iow;
    assign w_wr_cmd   = w_sel & r_iow_q & ~bus.isa_iow & bus.isa_ior;
    assign w_idle     = (r_state == ST_IDLE);
    assign w_start_rd = w_idle & w_rd_cmd & (w_off == OFF_DATA_LO);
    assign w_start_wr = w_idle & w_wr_cmd & (w_off == OFF_DATA_HI);
    assign w_reg_wr   = w_idle & w_wr_cmd;
    assign w_clr_pend = w_reg_wr & (w_off == OFF_CTRL) & bus.isa_data_in[CTRL_CLR_PENDING];

    always_ff @(posedge isa_clk) begin
        if (isa_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_ack        = 1'b0;
        w_to_hit     = 1'b0;
        w_chrdy      = 1'b1;
        w_strobe     = 1'b0;
        w_cb_addr    = '0;
        w_cb_dout    = '0;
        w_cb_oe      = 1'b0;
        w_cb_write   = 1'b0;
        if (r_state != ST_IDLE) begin
            w_cb_addr  = r_addr;
            w_cb_write = r_is_write;
            w_cb_oe    = r_is_write;
            if (r_is_write) begin
                w_cb_dout = r_data;
            end
        end
        case (r_state)
            ST_IDLE: begin
                if (w_start_rd || w_start_wr) begin
                    w_next_state = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_chrdy = 1'b0;
                if (r_cnt == SETUP_LAST) begin
                    w_next_state = ST_STROBE;
                end
            end
            ST_STROBE: begin
                w_chrdy  = 1'b0;
                w_strobe = 1'b1;
                if (!w_prr_sync) begin
                    w_ack        = 1'b1;
                    w_next_state = ST_HOLD;
                end else if (r_cnt == TO_LAST) begin
                    w_to_hit     = 1'b1;
                    w_next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // After a timeout the crate never drove prr, so there is nothing to wait for.
                w_chrdy = 1'b0;
                if (w_prr_sync || r_cyc_to) begin
                    w_next_state = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (bus.isa_ior && bus.isa_iow) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // One counter serves both SETUP and STROBE; it restarts on every state change and saturates.
    always_ff @(posedge isa_clk) begin
        if (isa_reset) begin
            r_cnt <= '0;
        end else if (w_next_state != r_state) begin
            r_cnt <= '0;
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_rd_mux = 8'h00;
        case (w_off)
            OFF_DATA_LO: w_rd_mux = r_data[7:0];
            OFF_DATA_HI: w_rd_mux = r_data[15:8];
            OFF_ADDR_LO: w_rd_mux = r_addr[7:0];
            OFF_ADDR_HI: w_rd_mux = {4'h0, r_addr[11:8]};
            OFF_CTRL:    w_rd_mux = pack_status(~w_idle, r_timeout, r_pending, r_irq_en);
            default:     w_rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge isa_clk) begin
        if (isa_reset) begin
            r_ior_q    <= 1'b0;
            r_iow_q    <= 1'b0;
            r_data     <= '0;
            r_addr     <= '0;
            r_timeout  <= 1'b0;
            r_pending  <= 1'b0;
            r_irq_en   <= 1'b0;
            r_is_write <= 1'b0;
            r_cyc_to   <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_ior_q    <= bus.isa_ior;
            r_iow_q    <= bus.isa_iow;
            r_data_out <= w_rd_mux;
            if (w_reg_wr) begin
                case (w_off)
                    OFF_DATA_LO: r_data[7:0]  <= bus.isa_data_in;
                    OFF_DATA_HI: r_data[15:8] <= bus.isa_data_in;
                    OFF_ADDR_LO: r_addr[7:0]  <= bus.isa_data_in;
                    OFF_ADDR_HI: r_addr[11:8] <= bus.isa_data_in[3:0];
                    OFF_CTRL: begin
                        if (bus.isa_data_in[CTRL_CLR_TIMEOUT]) begin
                            r_timeout <= 1'b0;
                        end
                        if (bus.isa_data_in[CTRL_SET_IRQ_EN]) begin
                            r_irq_en <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (w_start_rd || w_start_wr) begin
                r_is_write <= w_start_wr;
                r_cyc_to   <= 1'b0;
            end
            if (w_ack && !r_is_write) begin
                r_data <= bus.cb_data_in;
            end
            if (w_to_hit) begin
                r_timeout <= 1'b1;
                r_cyc_to  <= 1'b1;
                if (!r_is_write) begin
                    r_data <= 16'hFFFF;
                end
            end
            if (w_zk4_fall) begin
                r_pending <= 1'b1;
            end else if (w_clr_pend) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        w_irq           = 8'h00;
        w_irq[IRQ_LINE] = r_pending & r_irq_en;
    end

    assign bus.isa_data_out = r_data_out;
    assign bus.isa_data_oe  = w_win & ~bus.isa_ior & ~bus.isa_aen;
    assign bus.isa_chrdy    = w_chrdy;
    assign bus.isa_irq      = w_irq;
    assign bus.cb_addr      = w_cb_addr;
    assign bus.cb_data_out  = w_cb_dout;
    assign bus.cb_data_oe   = w_cb_oe;
    assign bus.cb_strobe    = w_strobe;
    assign bus.cb_write     = w_cb_write;

    assign o_dbg.state    = r_state;
    assign o_dbg.prr_sync = w_prr_sync;
    assign o_dbg.prr_fall = w_prr_fall;
    assign o_dbg.zk4_sync = w_zk4_sync;
    assign o_dbg.cnt      = r_cnt;

endmodule

// File: tb/tb_sm2201_camac_cycle_controller.sv
// Directed bench for the SM2201 CAMAC cycle controller (SETUP_CYCLES=1, TIMEOUT_CYCLES=64).
module tb_sm2201_camac_cycle_controller;
    import sm2201_camac_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    dbg_t dut_dbg;
    int   n_asserts = 0;
    int   n_fail    = 0;
    int   w;
    logic [7:0] q;

    sm2201_camac_cycle_controller_if bus_if ();

    sm2201_camac_cycle_controller #(
        .BASE_ADDR      (10'h110),
        .SETUP_CYCLES   (1),
        .TIMEOUT_CYCLES (64),
        .IRQ_LINE       (5)
    ) dut (
        .isa_clk   (clk),
        .isa_reset (rst),
        .bus       (bus_if),
        .o_dbg     (dut_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Full ISA cycle: strobe low, wait (bounded) for chrdy, capture read data, release.
    task automatic isa_cycle(input logic rd, input logic [9:0] a, input logic [7:0] d,
                             output logic [7:0] rq, output int wc);
        bus_if.isa_addr    = a;
        bus_if.isa_data_in = d;
        if (rd) bus_if.isa_ior = 1'b0;
        else    bus_if.isa_iow = 1'b0;
        tick();
        wc = 0;
        while (bus_if.isa_chrdy !== 1'b1 && wc < 400) begin
            tick();
            wc++;
        end
        rq = bus_if.isa_data_out;
        bus_if.isa_ior = 1'b1;
        bus_if.isa_iow = 1'b1;
        tick();
        tick();
    endtask

    task automatic isa_rd(input logic [9:0] a, output logic [7:0] rq);
        int wc;
        isa_cycle(1'b1, a, 8'h00, rq, wc);
    endtask

    task automatic isa_wr(input logic [9:0] a, input logic [7:0] d);
        int wc;
        logic [7:0] dummy;
        isa_cycle(1'b0, a, d, dummy, wc);
    endtask

    initial begin
        bus_if.isa_ior     = 1'b1;
        bus_if.isa_iow     = 1'b1;
        bus_if.isa_aen     = 1'b0;
        bus_if.isa_addr    = 10'h000;
        bus_if.isa_data_in = 8'h00;
        bus_if.cb_data_in  = 16'h0000;
        bus_if.cb_prr      = 1'b1;
        bus_if.cb_zk4      = 1'b1;

        // Reset state
        tick(); tick(); tick();
        chk("rst_chrdy",    bus_if.isa_chrdy, 1'b1);
        chk("rst_strobe",   bus_if.cb_strobe, 1'b0);
        chk("rst_irq",      bus_if.isa_irq, 8'h00);
        chk("rst_data_out", bus_if.isa_data_out, 8'h00);
        chk("rst_cb_addr",  bus_if.cb_addr, 12'h000);
        chk("rst_state",    32'(dut_dbg.state), 32'(ST_IDLE));
        rst = 1'b0;
        tick(); tick(); tick(); tick();

        // Address register access; upper nibble of offset 3 reads back 0
        isa_wr(10'h113, 8'hA5);
        isa_rd(10'h113, q);
        chk("addr_hi_nibble", q, 8'h05);
        isa_wr(10'h113, 8'h00);
        isa_wr(10'h112, 8'h13);
        isa_rd(10'h112, q);
        chk("addr_lo", q, 8'h13);

        // CAMAC read, crate acknowledges 4 clocks after strobe rises
        bus_if.cb_data_in = 16'h4208;
        bus_if.isa_addr   = 10'h110;
        bus_if.isa_ior    = 1'b0;
        tick();                                   // N: SETUP
        chk("rd_chrdy_low", bus_if.isa_chrdy, 1'b0);
        chk("rd_cb_addr",   bus_if.cb_addr, 12'h013);
        chk("rd_setup_nostb", bus_if.cb_strobe, 1'b0);
        chk("rd_data_oe",   bus_if.isa_data_oe, 1'b1);
        tick();                                   // N+1: STROBE
        chk("rd_strobe",    bus_if.cb_strobe, 1'b1);
        chk("rd_cb_write",  bus_if.cb_write, 1'b0);
        chk("rd_cb_oe",     bus_if.cb_data_oe, 1'b0);
        tick(); tick(); tick();                   // N+4
        bus_if.cb_prr = 1'b0;                     // sampled at M = N+5
        tick(); tick();                           // N+6
        chk("rd_strobe_sync", bus_if.cb_strobe, 1'b1);
        tick();                                   // N+7 = M+2: HOLD
        chk("rd_hold_nostb", bus_if.cb_strobe, 1'b0);
        chk("rd_hold_chrdy", bus_if.isa_chrdy, 1'b0);
        bus_if.cb_prr = 1'b1;
        w = 7;
        while (bus_if.isa_chrdy !== 1'b1 && w < 400) begin
            tick();
            w++;
        end
        chk("rd_wait_clks", w, 10);
        chk("rd_data_lo", bus_if.isa_data_out, 8'h08);
        bus_if.isa_ior = 1'b1;
        tick(); tick();
        chk("rd_back_idle", 32'(dut_dbg.state), 32'(ST_IDLE));
        isa_rd(10'h111, q);
        chk("rd_data_hi", q, 8'h42);

        // CAMAC write of 16'h1234
        isa_wr(10'h110, 8'h34);
        bus_if.isa_addr    = 10'h111;
        bus_if.isa_data_in = 8'h12;
        bus_if.isa_iow     = 1'b0;
        tick();                                   // N: SETUP
        chk("wr_cb_write",  bus_if.cb_write, 1'b1);
        chk("wr_cb_oe",     bus_if.cb_data_oe, 1'b1);
        chk("wr_setup_dout", bus_if.cb_data_out, 16'h1234);
        chk("wr_chrdy_low", bus_if.isa_chrdy, 1'b0);
        tick();                                   // N+1: STROBE
        chk("wr_strobe",    bus_if.cb_strobe, 1'b1);
        chk("wr_stb_dout",  bus_if.cb_data_out, 16'h1234);
        bus_if.cb_prr = 1'b0;
        tick(); tick(); tick();                   // N+4: HOLD
        chk("wr_hold_nostb", bus_if.cb_strobe, 1'b0);
        chk("wr_hold_chrdy", bus_if.isa_chrdy, 1'b0);
        bus_if.cb_prr = 1'b1;
        tick(); tick();                           // N+6
        chk("wr_wait_prr_hi", bus_if.isa_chrdy, 1'b0);
        tick();                                   // N+7: RELEASE
        chk("wr_release", bus_if.isa_chrdy, 1'b1);
        bus_if.isa_iow = 1'b1;
        tick();
        chk("wr_oe_drop",   bus_if.cb_data_oe, 1'b0);
        tick();

        // No acknowledge: timeout
        isa_cycle(1'b1, 10'h110, 8'h00, q, w);
        chk("to_wait_clks", w, 66);
        chk("to_data_lo", q, 8'hFF);
        isa_rd(10'h111, q);
        chk("to_data_hi", q, 8'hFF);
        isa_rd(10'h114, q);
        chk("to_status", q, 8'h40);
        isa_wr(10'h114, 8'h01);
        isa_rd(10'h114, q);
        chk("to_cleared", q, 8'h00);

        // Service request to IRQ
        bus_if.cb_zk4 = 1'b0;
        tick(); tick(); tick(); tick();
        bus_if.cb_zk4 = 1'b1;
        tick(); tick(); tick(); tick();
        chk("irq_masked", bus_if.isa_irq, 8'h00);
        isa_rd(10'h114, q);
        chk("irq_pending_stat", q, 8'h20);
        isa_wr(10'h114, 8'h02);
        chk("irq_enabled", bus_if.isa_irq, 8'h20);
        isa_rd(10'h114, q);
        chk("irq_en_stat", q, 8'h30);
        bus_if.cb_zk4 = 1'b0;                     // A
        tick(); tick();                           // A+2: fall pulse active
        bus_if.isa_addr    = 10'h114;
        bus_if.isa_data_in = 8'h04;
        bus_if.isa_iow     = 1'b0;
        tick();                                   // A+3: set and clear together
        bus_if.isa_iow = 1'b1;
        bus_if.cb_zk4  = 1'b1;
        tick(); tick(); tick();
        chk("irq_set_wins", bus_if.isa_irq, 8'h20);
        isa_wr(10'h114, 8'h04);
        chk("irq_cleared", bus_if.isa_irq, 8'h00);
        isa_rd(10'h114, q);
        chk("irq_clr_stat", q, 8'h10);

        // Ignored cycles: DMA, outside the window, both strobes low
        bus_if.isa_aen  = 1'b1;
        bus_if.isa_addr = 10'h110;
        bus_if.isa_ior  = 1'b0;
        tick();
        chk("aen_data_oe", bus_if.isa_data_oe, 1'b0);
        tick(); tick();
        chk("aen_nostb",  bus_if.cb_strobe, 1'b0);
        chk("aen_chrdy",  bus_if.isa_chrdy, 1'b1);
        bus_if.isa_ior = 1'b1;
        bus_if.isa_aen = 1'b0;
        tick();
        bus_if.isa_addr = 10'h118;
        bus_if.isa_ior  = 1'b0;
        tick();
        chk("win_data_oe", bus_if.isa_data_oe, 1'b0);
        tick(); tick();
        chk("win_idle", 32'(dut_dbg.state), 32'(ST_IDLE));
        bus_if.isa_ior = 1'b1;
        tick();
        bus_if.isa_addr    = 10'h111;
        bus_if.isa_data_in = 8'h77;
        bus_if.isa_ior     = 1'b0;
        bus_if.isa_iow     = 1'b0;
        tick(); tick(); tick();
        chk("both_idle", 32'(dut_dbg.state), 32'(ST_IDLE));
        bus_if.isa_ior = 1'b1;
        bus_if.isa_iow = 1'b1;
        tick();
        isa_rd(10'h111, q);
        chk("both_no_write", q, 8'hFF);
        isa_rd(10'h115, q);
        chk("off5_zero", q, 8'h00);

        // Reset in the middle of a strobe
        bus_if.isa_addr = 10'h110;
        bus_if.isa_ior  = 1'b0;
        tick(); tick();
        chk("mid_strobe", bus_if.cb_strobe, 1'b1);
        rst = 1'b1;
        tick();
        chk("mid_rst_nostb", bus_if.cb_strobe, 1'b0);
        chk("mid_rst_chrdy", bus_if.isa_chrdy, 1'b1);
        chk("mid_rst_state", 32'(dut_dbg.state), 32'(ST_IDLE));
        rst = 1'b0;
        bus_if.isa_ior = 1'b1;
        tick(); tick(); tick();
        isa_rd(10'h112, q);
        chk("mid_rst_addr", q, 8'h00);
        isa_rd(10'h111, q);
        chk("mid_rst_data", q, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
